// File: rtl/ndarray_unpack_buffer_if.sv
// Serial-element in / assembled-frame out bundle for the ND-array unpack buffer.
// Producer drives I_* and O_ready; the buffer drives I_ready, O, O_valid and fill_count.
interface ndarray_unpack_buffer_if #(
  parameter int ROWS = 4
);
  localparam int CW = $clog2(ROWS * 4 + 1);

  logic [2:0]    I_data;
  logic          I_valid;
  logic          I_ready;
  logic          I_abort;
  logic [2:0]    O [ROWS-1:0][3:0];
  logic          O_valid;
  logic          O_ready;
  logic [CW-1:0] fill_count;

  modport master (
    output I_data, I_valid, I_abort, O_ready,
    input  I_ready, O, O_valid, fill_count
  );

  modport slave (
    input  I_data, I_valid, I_abort, O_ready,
    output I_ready, O, O_valid, fill_count
  );
endinterface

// File: rtl/ndarray_unpack_buffer.sv
// Scatters a row-major serial stream into a ROWS x 4 frame; O_valid rises the cycle after the last accept.
// While the frame waits for O_ready the input is stalled (I_ready low) and O holds.
module ndarray_unpack_buffer #(
  parameter int ROWS = 4
) (
  input  logic                  CLK,
  input  logic                  ASYNCRESET,
  ndarray_unpack_buffer_if.slave bus
);
  localparam int COLS = 4;
  localparam int W    = 3;
  localparam int N    = ROWS * COLS;
  localparam int CW   = $clog2(N + 1);
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic {FILL, FULL} state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] row;
  logic [1:0]    col;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          last;
  logic          consume;
  logic          clear;
  logic [W-1:0]  elem;

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) state <= FILL;
    else            state <= state_nxt;
  end

  // Abort outranks a coincident valid element, so the element is dropped.
  always_comb begin
    accept    = 1'b0;
    last      = 1'b0;
    consume   = 1'b0;
    clear     = 1'b0;
    state_nxt = state;
    case (state)
      FILL: begin
        accept = bus.I_valid && !bus.I_abort;
        last   = accept && (row == RW'(ROWS - 1)) && (col == 2'd3);
        clear  = bus.I_abort;
        if (last) state_nxt = FULL;
      end
      FULL: begin
        consume = bus.O_ready;
        clear   = bus.O_ready;
        if (consume) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  assign bus.I_ready    = (state == FILL);
  assign bus.O_valid    = (state == FULL);
  assign bus.fill_count = cnt;

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      row <= '0;
      col <= '0;
      cnt <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + CW'(1);
      col <= col + 2'd1;
      if (col == 2'd3) row <= last ? '0 : row + RW'(1);
    end
  end

  // Stored value swaps bits 1 and 2; column p(c) = -c mod 4 is its own inverse.
  assign elem = {bus.I_data[1], bus.I_data[2], bus.I_data[0]};

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          bus.O[r][c] <= '0;
        end
      end
    end else if (accept) begin
      bus.O[row][2'd0 - col] <= elem;
    end
  end
endmodule

// File: tb/tb_ndarray_unpack_buffer.sv
// Directed bench: ordering, backpressure, abort, async reset and gather round trips for ROWS=1/4/6.
// Accepted stream elements go to a queue; each completed frame is gathered back and popped in order.
module tb_ndarray_unpack_buffer;
  logic CLK = 1'b0;
  logic ASYNCRESET = 1'b1;
  always #5 CLK = ~CLK;

  ndarray_unpack_buffer_if #(.ROWS(4)) b4 ();
  ndarray_unpack_buffer_if #(.ROWS(1)) b1 ();
  ndarray_unpack_buffer_if #(.ROWS(6)) b6 ();

  ndarray_unpack_buffer #(.ROWS(4)) u4 (.CLK(CLK), .ASYNCRESET(ASYNCRESET), .bus(b4));
  ndarray_unpack_buffer #(.ROWS(1)) u1 (.CLK(CLK), .ASYNCRESET(ASYNCRESET), .bus(b1));
  ndarray_unpack_buffer #(.ROWS(6)) u6 (.CLK(CLK), .ASYNCRESET(ASYNCRESET), .bus(b6));

  int compared = 0;
  int mismatched = 0;
  logic [2:0] sb4[$];
  logic [2:0] sb1[$];
  logic [2:0] sb6[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [2:0] unswap(input logic [2:0] v);
    return {v[1], v[2], v[0]};
  endfunction

  // Gather: stream element k sits at row k/4, column (4 - k%4) % 4, bits 1/2 exchanged.
  task automatic gather4(input string tag);
    logic [2:0] exp;
    for (int k = 0; k < 16; k++) begin
      exp = (sb4.size() > 0) ? sb4.pop_front() : 3'bxxx;
      chk(tag, {29'd0, unswap(b4.O[k/4][(4 - k%4) % 4])}, {29'd0, exp});
    end
  endtask

  task automatic gather1(input string tag);
    logic [2:0] exp;
    for (int k = 0; k < 4; k++) begin
      exp = (sb1.size() > 0) ? sb1.pop_front() : 3'bxxx;
      chk(tag, {29'd0, unswap(b1.O[0][(4 - k%4) % 4])}, {29'd0, exp});
    end
  endtask

  task automatic gather6(input string tag);
    logic [2:0] exp;
    for (int k = 0; k < 24; k++) begin
      exp = (sb6.size() > 0) ? sb6.pop_front() : 3'bxxx;
      chk(tag, {29'd0, unswap(b6.O[k/4][(4 - k%4) % 4])}, {29'd0, exp});
    end
  endtask

  function automatic logic o4_nonzero();
    logic nz = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        nz = nz | (|b4.O[r][c]);
    return nz;
  endfunction

  task automatic rt1(input int frames);
    for (int f = 0; f < frames; f++) begin
      int acc = 0;
      int guard = 0;
      while (acc < 4 && guard < 200) begin
        b1.I_valid = ($urandom_range(0, 3) != 0);
        b1.I_data  = 3'($urandom);
        if (b1.I_valid && b1.I_ready) begin
          sb1.push_back(b1.I_data);
          acc++;
        end
        guard++;
        tick();
      end
      b1.I_valid = 1'b0;
      chk("rt1_o_valid", {31'd0, b1.O_valid}, 32'd1);
      chk("rt1_fill_count", {29'd0, b1.fill_count}, 32'd4);
      gather1("rt1_gather");
      b1.O_ready = 1'b1;
      tick();
      b1.O_ready = 1'b0;
      chk("rt1_i_ready", {31'd0, b1.I_ready}, 32'd1);
    end
  endtask

  task automatic rt6(input int frames);
    for (int f = 0; f < frames; f++) begin
      int acc = 0;
      int guard = 0;
      while (acc < 24 && guard < 500) begin
        b6.I_valid = ($urandom_range(0, 3) != 0);
        b6.I_data  = 3'($urandom);
        if (b6.I_valid && b6.I_ready) begin
          sb6.push_back(b6.I_data);
          acc++;
        end
        guard++;
        tick();
      end
      b6.I_valid = 1'b0;
      chk("rt6_o_valid", {31'd0, b6.O_valid}, 32'd1);
      chk("rt6_fill_count", {27'd0, b6.fill_count}, 32'd24);
      gather6("rt6_gather");
      b6.O_ready = 1'b1;
      tick();
      b6.O_ready = 1'b0;
      chk("rt6_fill_clear", {27'd0, b6.fill_count}, 32'd0);
    end
  endtask

  initial begin
    b4.I_data = '0; b4.I_valid = 1'b0; b4.I_abort = 1'b0; b4.O_ready = 1'b0;
    b1.I_data = '0; b1.I_valid = 1'b0; b1.I_abort = 1'b0; b1.O_ready = 1'b0;
    b6.I_data = '0; b6.I_valid = 1'b0; b6.I_abort = 1'b0; b6.O_ready = 1'b0;

    #2;
    chk("rst_i_ready", {31'd0, b4.I_ready}, 32'd1);
    chk("rst_o_valid", {31'd0, b4.O_valid}, 32'd0);
    chk("rst_fill_count", {27'd0, b4.fill_count}, 32'd0);
    chk("rst_o_zero", {31'd0, o4_nonzero()}, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    ASYNCRESET = 1'b0;
    tick();

    // Ordering: I_data = k%8, valid held high, consumer idle.
    b4.I_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      b4.I_data = 3'(k % 8);
      if (k == 15) chk("order_o_valid_before_last", {31'd0, b4.O_valid}, 32'd0);
      sb4.push_back(b4.I_data);
      tick();
      chk("order_fill_count", {27'd0, b4.fill_count}, 32'(k + 1));
    end
    chk("order_o_valid", {31'd0, b4.O_valid}, 32'd1);
    chk("order_i_ready_full", {31'd0, b4.I_ready}, 32'd0);

    // Backpressure: keep offering data while the frame waits.
    for (int i = 0; i < 10; i++) begin
      b4.I_data = 3'(i);
      tick();
      chk("bp_o_valid", {31'd0, b4.O_valid}, 32'd1);
      chk("bp_i_ready", {31'd0, b4.I_ready}, 32'd0);
      chk("bp_fill_count", {27'd0, b4.fill_count}, 32'd16);
    end
    chk("order_o03", {29'd0, b4.O[0][3]}, 32'b001);
    chk("order_o01", {29'd0, b4.O[0][1]}, 32'b101);
    chk("order_o02", {29'd0, b4.O[0][2]}, 32'b100);
    chk("order_o30", {29'd0, b4.O[3][0]}, 32'b010);
    gather4("order_gather");
    b4.I_valid = 1'b0;
    b4.O_ready = 1'b1;
    tick();
    b4.O_ready = 1'b0;
    chk("consume_i_ready", {31'd0, b4.I_ready}, 32'd1);
    chk("consume_o_valid", {31'd0, b4.O_valid}, 32'd0);
    chk("consume_fill_count", {27'd0, b4.fill_count}, 32'd0);
    chk("consume_o_retained", {29'd0, b4.O[0][1]}, 32'b101);

    // Abort: five accepts, then abort with a coincident valid element.
    b4.I_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b4.I_data = 3'(7 - i);
      tick();
    end
    chk("abort_pre_count", {27'd0, b4.fill_count}, 32'd5);
    b4.I_abort = 1'b1;
    b4.I_data  = 3'b110;
    tick();
    b4.I_abort = 1'b0;
    chk("abort_fill_count", {27'd0, b4.fill_count}, 32'd0);
    chk("abort_i_ready", {31'd0, b4.I_ready}, 32'd1);
    chk("abort_dropped_o13", {29'd0, b4.O[1][3]}, 32'b011);
    for (int i = 0; i < 16; i++) begin
      b4.I_data  = 3'((3 * i + 5) % 8);
      b4.O_ready = (i == 8);
      sb4.push_back(b4.I_data);
      tick();
      if (i == 8) chk("fill_o_ready_ignored", {27'd0, b4.fill_count}, 32'd9);
    end
    b4.O_ready = 1'b0;
    b4.I_valid = 1'b0;
    chk("abort_frame_o_valid", {31'd0, b4.O_valid}, 32'd1);
    chk("abort_frame_o00", {29'd0, b4.O[0][0]}, 32'b011);
    b4.I_abort = 1'b1;
    tick();
    b4.I_abort = 1'b0;
    chk("full_abort_o_valid", {31'd0, b4.O_valid}, 32'd1);
    chk("full_abort_fill_count", {27'd0, b4.fill_count}, 32'd16);
    gather4("abort_gather");
    b4.O_ready = 1'b1;
    tick();
    b4.O_ready = 1'b0;

    // Reset asserted between edges after seven accepts.
    b4.I_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      b4.I_data = 3'($urandom);
      tick();
    end
    b4.I_valid = 1'b0;
    #3;
    ASYNCRESET = 1'b1;
    #1;
    chk("midrst_o_zero", {31'd0, o4_nonzero()}, 32'd0);
    chk("midrst_o_valid", {31'd0, b4.O_valid}, 32'd0);
    chk("midrst_fill_count", {27'd0, b4.fill_count}, 32'd0);
    chk("midrst_i_ready", {31'd0, b4.I_ready}, 32'd1);
    @(negedge CLK);
    ASYNCRESET = 1'b0;
    sb4.delete();
    tick();

    rt1(4);
    rt6(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
